// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in serial-out serializer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int PISO_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/piso_bit_cnt.sv
// Remaining-bit counter: load, decrement or hold each clock; zero flag is combinational from the count.
// Decrement is ignored at zero so the count never wraps.
module piso_bit_cnt #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/piso_serializer.sv
// LSB-first serializer: bit i of a word accepted at edge T is on data_out after edge T+i.
// load_ready opens in IDLE or on the last bit, so back-to-back words stream with no gap; en=0 stalls everything.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             data_out,
  output logic             out_valid,
  output logic             last,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             cnt_zero;
  logic             take;
  logic             step;

  // Ready depends only on state and count so a source may wait on it before raising valid.
  assign load_ready = !clr && ((state == IDLE) || cnt_zero);
  assign take       = load_valid && load_ready && en;
  assign step       = en && (state == SHIFT) && !take;

  piso_bit_cnt #(
    .CW(CW)
  ) u_bit_cnt (
    .clk     (clk),
    .clr     (clr),
    .load    (take),
    .dec     (step),
    .load_val(CNT_INIT),
    .cnt     (cnt),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      sreg     <= '0;
      data_out <= 1'b0;
    end else if (en) begin
      if (take) begin
        state    <= SHIFT;
        sreg     <= load_data;
        data_out <= load_data[0];
      end else if (state == SHIFT) begin
        if (cnt_zero) begin
          state    <= IDLE;
          sreg     <= '0;
          data_out <= 1'b0;
        end else begin
          sreg     <= sreg >> 1;
          data_out <= sreg[1];
        end
      end
    end
  end

  // A stalled cycle carries no payload: the held bit is re-presented once en returns.
  assign busy      = (state == SHIFT);
  assign out_valid = busy && en;
  assign last      = out_valid && cnt_zero;

endmodule

// File: tb/tb_piso_serializer.sv
// Serializer bench: a queue of pending bits predicts every output cycle by cycle; a SIPO receiver checks whole words.
module tb_piso_serializer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clr;
  logic         en;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready;
  logic         data_out;
  logic         out_valid;
  logic         last;
  logic         busy;

  piso_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .clr       (clr),
    .en        (en),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .last      (last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int           n_run  = 0;
  int           n_fail = 0;
  bit           q[$];      // bits still to be shown; q[0] is the one on data_out now
  logic [W-1:0] sent[$];   // words accepted, in order
  logic [W-1:0] rx;
  logic         e_dout, e_vld, e_last, e_busy, e_rdy;
  logic         s_vld, s_dout, s_last;

  // Expected outputs for the current cycle, from the pending-bit queue and the driven inputs.
  task automatic eval();
    #1;
    e_busy = (q.size() > 0);
    e_vld  = e_busy && en;
    e_last = e_vld && (q.size() == 1);
    e_dout = e_busy ? q[0] : 1'b0;
    e_rdy  = !clr && (q.size() <= 1);
  endtask

  // One clock: snapshot outputs, update the model and receiver at the edge, return at the falling edge.
  task automatic adv();
    bit hs;
    s_vld  = out_valid;
    s_dout = data_out;
    s_last = last;
    @(posedge clk);
    if (clr) begin
      q.delete();
    end else if (en) begin
      hs = load_valid && e_rdy;
      if (q.size() > 0) void'(q.pop_front());
      if (hs) begin
        for (int i = 0; i < W; i++) q.push_back(load_data[i]);
        sent.push_back(load_data);
      end
    end
    if (s_vld) rx = {s_dout, rx[W-1:1]};
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr = 1'b1; en = 1'b1; load_valid = 1'b1; load_data = 4'hF;
    @(negedge clk);
    eval(); adv();
    for (int c = 0; c < 2; c++) begin
      eval();
      n_run++;
      if ({data_out, out_valid, last, busy, load_ready} !== {e_dout, e_vld, e_last, e_busy, e_rdy}) begin
        n_fail++;
        $display("FAIL reset_hold c%0d: got %b want %b", c,
                 {data_out, out_valid, last, busy, load_ready}, {e_dout, e_vld, e_last, e_busy, e_rdy});
      end
      adv();
    end
    clr = 1'b0; load_valid = 1'b0;
    eval();
    n_run++;
    if ({data_out, out_valid, last, busy, load_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_release: got %b want 00001", {data_out, out_valid, last, busy, load_ready});
    end
  endtask

  task automatic test_single();
    logic [W-1:0] got = '0;
    int k = 0, nlast = 0;
    en = 1'b1;
    for (int c = 0; c < 7; c++) begin
      load_valid = (c == 0);
      load_data  = (c == 0) ? 4'b1011 : W'($urandom);
      eval();
      n_run++;
      if ({data_out, out_valid, last, busy, load_ready} !== {e_dout, e_vld, e_last, e_busy, e_rdy}) begin
        n_fail++;
        $display("FAIL single c%0d: got %b want %b", c,
                 {data_out, out_valid, last, busy, load_ready}, {e_dout, e_vld, e_last, e_busy, e_rdy});
      end
      adv();
      if (s_vld && k < W) begin got[k] = s_dout; k++; end
      if (s_last) nlast++;
    end
    n_run++;
    if (got !== 4'b1011 || k != 4 || nlast != 1) begin
      n_fail++;
      $display("FAIL single_word: got %b bits=%0d lasts=%0d want 1011 bits=4 lasts=1", got, k, nlast);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq = '0;
    int k = 0, run = 0, best = 0, nlast = 0;
    bit pend = 1'b0, acc;
    en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      load_valid = (c == 0) || pend;
      load_data  = (c == 0) ? 4'hA : 4'h5;
      eval();
      n_run++;
      if ({data_out, out_valid, last, busy, load_ready} !== {e_dout, e_vld, e_last, e_busy, e_rdy}) begin
        n_fail++;
        $display("FAIL b2b c%0d: got %b want %b", c,
                 {data_out, out_valid, last, busy, load_ready}, {e_dout, e_vld, e_last, e_busy, e_rdy});
      end
      acc = load_valid && e_rdy;
      adv();
      if (c == 0) pend = 1'b1;
      else if (acc) pend = 1'b0;
      if (s_vld) begin
        if (k < 8) seq[k] = s_dout;
        k++; run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
      if (s_last) nlast++;
    end
    load_valid = 1'b0;
    n_run++;
    if (seq !== 8'h5A || best != 8 || nlast != 2) begin
      n_fail++;
      $display("FAIL b2b_stream: got seq=%h run=%0d lasts=%0d want seq=5a run=8 lasts=2", seq, best, nlast);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] got = '0;
    int k = 0;
    for (int c = 0; c < 10; c++) begin
      en         = !(c >= 3 && c <= 5);
      load_valid = (c == 0);
      load_data  = (c == 0) ? 4'hC : W'($urandom);
      eval();
      n_run++;
      if ({data_out, out_valid, last, busy, load_ready} !== {e_dout, e_vld, e_last, e_busy, e_rdy}) begin
        n_fail++;
        $display("FAIL stall c%0d: got %b want %b", c,
                 {data_out, out_valid, last, busy, load_ready}, {e_dout, e_vld, e_last, e_busy, e_rdy});
      end
      adv();
      if (s_vld) begin
        if (k < W) got[k] = s_dout;
        k++;
      end
    end
    en = 1'b1; load_valid = 1'b0;
    n_run++;
    if (got !== 4'hC || k != 4) begin
      n_fail++;
      $display("FAIL stall_word: got %h bits=%0d want c bits=4", got, k);
    end
  endtask

  task automatic test_clr_mid();
    int k = 0;
    en = 1'b1;
    for (int c = 0; c < 9; c++) begin
      clr        = (c == 3);
      load_valid = (c == 0);
      load_data  = 4'hF;
      eval();
      n_run++;
      if ({data_out, out_valid, last, busy, load_ready} !== {e_dout, e_vld, e_last, e_busy, e_rdy}) begin
        n_fail++;
        $display("FAIL clr_mid c%0d: got %b want %b", c,
                 {data_out, out_valid, last, busy, load_ready}, {e_dout, e_vld, e_last, e_busy, e_rdy});
      end
      if (c == 4) begin
        n_run++;
        if ({data_out, out_valid, last, busy, load_ready} !== 5'b00001) begin
          n_fail++;
          $display("FAIL clr_after: got %b want 00001", {data_out, out_valid, last, busy, load_ready});
        end
      end
      adv();
      if (s_vld && c != 3) k++;
    end
    clr = 1'b0; load_valid = 1'b0;
    n_run++;
    if (k != 2) begin
      n_fail++;
      $display("FAIL clr_residual: got %0d valid bits want 2", k);
    end
  endtask

  task automatic test_loopback(input bit held);
    int nw = 0, cyc = 0;
    logic [W-1:0] want;
    sent.delete();
    while (nw < 100 && cyc < 4000) begin
      en         = held ? 1'b1 : ($urandom_range(0, 9) != 0);
      load_valid = held ? 1'b1 : 1'($urandom_range(0, 1));
      load_data  = W'($urandom);
      eval();
      n_run++;
      if ({data_out, out_valid, last, busy, load_ready} !== {e_dout, e_vld, e_last, e_busy, e_rdy}) begin
        n_fail++;
        $display("FAIL loop%0d c%0d: got %b want %b", held, cyc,
                 {data_out, out_valid, last, busy, load_ready}, {e_dout, e_vld, e_last, e_busy, e_rdy});
      end
      adv();
      cyc++;
      if (s_last) begin
        want = (sent.size() > 0) ? sent.pop_front() : 'x;
        n_run++;
        if (rx !== want) begin
          n_fail++;
          $display("FAIL loop%0d_word %0d: rx %h want %h", held, nw, rx, want);
        end
        nw++;
      end
    end
    n_run++;
    if (nw < 100) begin
      n_fail++;
      $display("FAIL loop%0d_budget: got %0d words want 100", held, nw);
    end
    load_valid = 1'b0; en = 1'b1;
    for (int c = 0; c < W + 1; c++) begin eval(); adv(); end
  endtask

  initial begin
    rx = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_clr_mid();
    test_loopback(1'b0);
    test_loopback(1'b1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
